clk_div_buf: RTL
================

// Module: clk_div_buf
// PURPOSE
//  Parametrised multi-channel clock divider/buffer model. Successor to the plain
//  single-input clock buffer model. Generates NUM_CH divided clocks from one
//  source clock, each with a programmable ratio, a glitch-free enable and a
//  matching clock-enable pulse. Used in simulation/prototype builds where the
//  controller needs slower derived clocks or strobes from the core clock.
// PARAMETERS
//  NUM_CH  4  number of independent divider channels
//  DIV_W   8  width of each channel's divide-ratio field
// PORTS
//  clk        in   1             source clock; all logic on its rising edge
//  rst_n      in   1             synchronous reset, active low
//  ch_en      in   NUM_CH        per-channel run request
//  div_ratio  in   NUM_CH*DIV_W  per-channel ratio R; ch i = [i*DIV_W +: DIV_W]
//  clk_out    out  NUM_CH        divided clock, registered, glitch-free
//  clk_ce     out  NUM_CH        1-cycle pulse in each cycle clk_out rises
//  ch_active  out  NUM_CH        channel currently running a period
// BEHAVIOUR
//  - Reset: rst_n=0 at a clk edge -> next cycle clk_out=0, clk_ce=0,
//    ch_active=0, counters=0, latched ratios=2. Reset has priority over all
//    inputs and aborts any period in progress with no partial pulse.
//  - Channels are fully independent. Per-channel state: cnt[DIV_W-1:0],
//    r_lat[DIV_W-1:0], active bit. Two states: IDLE (active=0), RUN (active=1).
//  - Ratio clamp: Reff = (div_ratio < 2) ? 2 : div_ratio. No bypass mode.
//    Max Reff = 2^DIV_W - 1.
//  - IDLE -> RUN: ch_en=1 sampled in IDLE. Next cycle: active=1, cnt=0,
//    r_lat=Reff, clk_out=1, clk_ce=1. Start latency is exactly 1 cycle.
//  - RUN counting: cnt increments each cycle, 0..r_lat-1, then wraps.
//    clk_out = 1 while cnt < ceil(r_lat/2), otherwise 0.
//    clk_ce = 1 only when cnt == 0.
//    Odd ratios: high phase is one cycle longer than low phase.
//  - Period boundary (cnt == r_lat-1, always in low phase):
//    - ch_en=1: cnt<=0; r_lat<=Reff of the current div_ratio (new ratio takes
//      effect here only); clk_out<=1; clk_ce<=1.
//    - ch_en=0: active<=0 (-> IDLE); clk_out stays 0; clk_ce=0.
//  - Mid-period changes: div_ratio changes are ignored until the next boundary.
//    Deasserting ch_en mid-period does not truncate; the current period
//    completes. Reasserting ch_en before the boundary cancels the stop.
//  - Glitch-free rule: clk_out never has a high or low phase shorter than
//    floor(r_lat/2) cycles, except the final low phase when stopping, which
//    lasts until restart.
//  - IDLE with ch_en=0: all channel outputs 0; div_ratio ignored.
//  - clk_out, clk_ce and ch_active are driven directly from flops. No
//    combinational path from any input to any output.
// TESTING
//  1 R=4, ch_en=1 from cycle 0 -> from cycle 1 clk_out=1100 repeating;
//    clk_ce high in cycles 1,5,9; ch_active=1 from cycle 1.
//  2 R=5 -> clk_out=11100 repeating, clk_ce every 5 cycles.
//  3 R=0 and R=1 -> both clamp to 2: clk_out=10 repeating, clk_ce every cycle
//    that clk_out=1.
//  4 R=4 running; set R=6 at cnt=1 -> rest of period stays 1100, then 111000.
//  5 R=6; drop ch_en at cnt=1 -> period finishes (cnt 2..5), then ch_active=0
//    and clk_out=0 held; reassert -> restart 1 cycle later with clk_ce=1.
//  6 Four channels at R=2,3,4,7 all running; pulse rst_n=0 for 1 cycle
//    mid-period -> all outputs 0 next cycle; with ch_en held, all channels
//    restart together in the cycle after rst_n returns to 1.

Source files
------------

// File: rtl/clk_div_buf.sv
// rtl/clk_div_buf.sv - multi-channel programmable clock divider with glitch-free enable and clock-enable pulse
// Each channel is an independent IDLE/RUN machine; every output comes straight from a flop.
module clk_div_buf #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         ch_en,
  input  logic [NUM_CH*DIV_W-1:0]   div_ratio,
  output logic [NUM_CH-1:0]         clk_out,
  output logic [NUM_CH-1:0]         clk_ce,
  output logic [NUM_CH-1:0]         ch_active
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] r_q, r_d;
    logic             active_q, active_d;
    logic             out_q, out_d;
    logic             ce_q, ce_d;

    logic [DIV_W-1:0] ratio;
    logic [DIV_W-1:0] reff;
    logic [DIV_W:0]   half;
    logic [DIV_W:0]   cnt_inc;
    logic             at_end;

    assign ratio   = div_ratio[i*DIV_W +: DIV_W];
    assign reff    = (ratio < DIV_W'(2)) ? DIV_W'(2) : ratio;
    // ceil(r/2) computed one bit wider so a ratio of 2^DIV_W-1 cannot overflow
    assign half    = ({1'b0, r_q} + (DIV_W+1)'(1)) >> 1;
    assign cnt_inc = {1'b0, cnt_q} + (DIV_W+1)'(1);
    assign at_end  = (cnt_q == r_q - DIV_W'(1));

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_q    <= '0;
        r_q      <= DIV_W'(2);
        active_q <= 1'b0;
        out_q    <= 1'b0;
        ce_q     <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        r_q      <= r_d;
        active_q <= active_d;
        out_q    <= out_d;
        ce_q     <= ce_d;
      end
    end

    always_comb begin
      cnt_d    = cnt_q;
      r_d      = r_q;
      active_d = active_q;
      out_d    = 1'b0;
      ce_d     = 1'b0;
      if (ch_en[i] && (!active_q || at_end)) begin
        // New period: the ratio is only sampled here, never mid-period
        active_d = 1'b1;
        cnt_d    = '0;
        r_d      = reff;
        out_d    = 1'b1;
        ce_d     = 1'b1;
      end else if (active_q) begin
        if (at_end) begin
          active_d = 1'b0;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_inc[DIV_W-1:0];
          out_d = (cnt_inc < half);
        end
      end
    end

    assign clk_out[i]   = out_q;
    assign clk_ce[i]    = ce_q;
    assign ch_active[i] = active_q;
  end

endmodule
